// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache controller:
// FSM state encoding, default geometry and the address field extractor.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOOKUP      = 3'd1,
    WRITEBACK   = 3'd2,
    REFILL_REQ  = 3'd3,
    REFILL_WAIT = 3'd4,
    MEM_WRITE   = 3'd5,
    RESPOND     = 3'd6
  } state_e;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_DATA_W   = 64;
  localparam int unsigned DEF_WAYS     = 4;
  localparam int unsigned DEF_SETS     = 128;
  localparam int unsigned DEF_OFFSET_W = 6;
  localparam int unsigned DEF_IDX_W    = $clog2(DEF_SETS);
  localparam int unsigned DEF_TAG_W    = DEF_ADDR_W - DEF_IDX_W - DEF_OFFSET_W;
  localparam int unsigned DEF_AGE_W    = $clog2(DEF_WAYS);

  // Extract a field of 'width' bits starting at bit 'lsb' (used for tag/index split).
  function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracker: one age per way per set, ages always a permutation
// of 0..WAYS-1. Victim choice prefers the lowest-index invalid way, otherwise
// the way carrying the maximum age.
module cache_lru #(
  parameter int unsigned WAYS = 4,
  parameter int unsigned SETS = 128,
  localparam int unsigned IDX_W = $clog2(SETS),
  localparam int unsigned AGE_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WAYS-1:0]  valid_i,
  input  logic             upd_i,
  input  logic [AGE_W-1:0] upd_way_i,
  output logic [AGE_W-1:0] victim_o
);

  logic [AGE_W-1:0] age_q [SETS][WAYS];
  logic [AGE_W-1:0] old_age_s;
  logic [AGE_W-1:0] inv_way_s;
  logic [AGE_W-1:0] old_way_s;
  logic             any_inv_s;

  // Victim select for the indexed set: invalid ways first, else the oldest way.
  always_comb begin
    inv_way_s = '0;
    old_way_s = '0;
    any_inv_s = 1'b0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      inv_way_s = valid_i[w] ? inv_way_s : AGE_W'(w);
      any_inv_s = any_inv_s | ~valid_i[w];
    end
    for (int w = 0; w < int'(WAYS); w++) begin
      old_way_s = (age_q[idx_i][w] == AGE_W'(WAYS - 1)) ? AGE_W'(w) : old_way_s;
    end
    victim_o  = any_inv_s ? inv_way_s : old_way_s;
    old_age_s = age_q[idx_i][upd_way_i];
  end

  // Age storage: reset to way index; on access the way goes to 0 and younger ways age by one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          age_q[s][w] <= AGE_W'(w);
        end
      end
    end else if (upd_i) begin
      for (int w = 0; w < int'(WAYS); w++) begin
        age_q[idx_i][w] <= (AGE_W'(w) == upd_way_i) ? '0 :
                           (age_q[idx_i][w] < old_age_s) ? age_q[idx_i][w] + AGE_W'(1) :
                           age_q[idx_i][w];
      end
    end
  end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-back cache controller, one DATA_W word per line.
// CPU request/response handshake on one side, valid/ready memory port on the other.
// Optional feature macro: CACHE_WRITE_ALLOCATE_EN -- when defined, write misses
// evict and install the line dirty; otherwise write misses go straight to memory.
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned WAYS     = 4,
  parameter int unsigned SETS     = 128,
  parameter int unsigned OFFSET_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFFSET_W;
  localparam int unsigned WAY_W = $clog2(WAYS);
`ifdef CACHE_WRITE_ALLOCATE_EN
  localparam bit WRITE_ALLOC = 1'b1;
`else
  localparam bit WRITE_ALLOC = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              hit_q, hit_d;
  logic [WAY_W-1:0]  victim_q, victim_d;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic [WAYS-1:0]   match_s;
  logic              hit_s;
  logic [WAY_W-1:0]  hit_way_s;
  logic [WAY_W-1:0]  victim_s;
  logic              victim_valid_s;
  logic              victim_dirty_s;

  logic              ln_we_s;
  logic [WAY_W-1:0]  ln_way_s;
  logic [DATA_W-1:0] ln_data_s;
  logic              ln_dirty_s;
  logic              wb_clr_s;
  logic              lru_upd_s;
  logic [WAY_W-1:0]  lru_way_s;

  // Split the latched address and compare its tag against every valid way of the set.
  always_comb begin
    idx_s     = IDX_W'(addr_field(64'(addr_q), OFFSET_W, IDX_W));
    tag_s     = TAG_W'(addr_field(64'(addr_q), OFFSET_W + IDX_W, TAG_W));
    hit_way_s = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      match_s[w] = valid_q[idx_s][w] & (tag_q[idx_s][w] == tag_s);
    end
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      hit_way_s = match_s[w] ? WAY_W'(w) : hit_way_s;
    end
    hit_s          = |match_s;
    victim_valid_s = valid_q[idx_s][victim_s];
    victim_dirty_s = dirty_q[idx_s][victim_s];
  end

  cache_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk       (clk),
    .reset     (reset),
    .idx_i     (idx_s),
    .valid_i   (valid_q[idx_s]),
    .upd_i     (lru_upd_s),
    .upd_way_i (lru_way_s),
    .victim_o  (victim_s)
  );

  // Next-state and line-update control for one outstanding transaction.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    victim_d   = victim_q;
    ln_we_s    = 1'b0;
    ln_way_s   = victim_q;
    ln_data_s  = wdata_q;
    ln_dirty_s = 1'b0;
    wb_clr_s   = 1'b0;
    lru_upd_s  = 1'b0;
    lru_way_s  = victim_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        rdata_d = '0;
        if (hit_s) begin
          hit_d     = 1'b1;
          lru_upd_s = 1'b1;
          lru_way_s = hit_way_s;
          if (write_q) begin
            ln_we_s    = 1'b1;
            ln_way_s   = hit_way_s;
            ln_dirty_s = 1'b1;
          end else begin
            rdata_d = data_q[idx_s][hit_way_s];
          end
          state_d = RESPOND;
        end else begin
          hit_d    = 1'b0;
          victim_d = victim_s;
          if (victim_valid_s && victim_dirty_s) begin
            state_d = WRITEBACK;
          end else if (write_q && WRITE_ALLOC) begin
            // Full-word write: install directly, no refill needed.
            ln_we_s    = 1'b1;
            ln_way_s   = victim_s;
            ln_dirty_s = 1'b1;
            lru_upd_s  = 1'b1;
            lru_way_s  = victim_s;
            state_d    = RESPOND;
          end else if (write_q) begin
            state_d = MEM_WRITE;
          end else begin
            state_d = REFILL_REQ;
          end
        end
      end
      WRITEBACK: begin
        if (mem_req_ready) begin
          wb_clr_s = 1'b1;
          if (write_q && WRITE_ALLOC) begin
            ln_we_s    = 1'b1;
            ln_dirty_s = 1'b1;
            lru_upd_s  = 1'b1;
            state_d    = RESPOND;
          end else if (write_q) begin
            state_d = MEM_WRITE;
          end else begin
            state_d = REFILL_REQ;
          end
        end else begin
          state_d = WRITEBACK;
        end
      end
      REFILL_REQ: begin
        state_d = mem_req_ready ? REFILL_WAIT : REFILL_REQ;
      end
      REFILL_WAIT: begin
        if (mem_resp_valid) begin
          ln_we_s    = 1'b1;
          ln_data_s  = mem_resp_rdata;
          ln_dirty_s = 1'b0;
          lru_upd_s  = 1'b1;
          rdata_d    = mem_resp_rdata;
          state_d    = RESPOND;
        end else begin
          state_d = REFILL_WAIT;
        end
      end
      MEM_WRITE: begin
        state_d = mem_req_ready ? RESPOND : MEM_WRITE;
      end
      RESPOND: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control/transaction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      hit_q    <= 1'b0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      hit_q    <= hit_d;
      victim_q <= victim_d;
    end
  end

  // Valid/dirty state; an install in the same cycle as a writeback clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (wb_clr_s) begin
        dirty_q[idx_s][victim_q] <= 1'b0;
      end
      if (ln_we_s) begin
        valid_q[idx_s][ln_way_s] <= 1'b1;
        dirty_q[idx_s][ln_way_s] <= ln_dirty_s;
      end
    end
  end

  // Tag/data arrays; writes suppressed under reset so an abandoned miss installs nothing.
  always_ff @(posedge clk) begin
    if (ln_we_s && !reset) begin
      tag_q[idx_s][ln_way_s]  <= tag_s;
      data_q[idx_s][ln_way_s] <= ln_data_s;
    end
  end

  // Port outputs decoded from registered state; stable while a memory request stalls.
  always_comb begin
    req_ready     = (state_q == IDLE);
    resp_valid    = (state_q == RESPOND);
    resp_rdata    = (state_q == RESPOND) ? rdata_q : '0;
    resp_hit      = (state_q == RESPOND) & hit_q;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[idx_s][victim_q], idx_s, {OFFSET_W{1'b0}}};
        mem_req_wdata = data_q[idx_s][victim_q];
      end
      REFILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_s, idx_s, {OFFSET_W{1'b0}}};
      end
      MEM_WRITE: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
      end
      default: begin
        mem_req_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed self-checking bench for assoc_cache_ctrl with a small memory model.
module tb_assoc_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid, resp_hit;
  logic [63:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mem_model [logic [31:0]];
  logic [31:0] log_addr  [$];
  logic        log_write [$];
  logic [63:0] log_wdata [$];
  logic        ready_en;
  logic        fire_rd;
  logic [31:0] rd_addr;

  logic [63:0] rd;
  logic        hit;
  int          lat;
  int          base;

  always #5 clk = ~clk;

  assoc_cache_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_hit       (resp_hit),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] set2_addr(input int t);
    return (32'(t) << 13) | 32'h80;
  endfunction

  // Memory side: ready follows ready_en; a read handshake gets its data one cycle later.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 64'd0;
    forever begin
      @(posedge clk);
      fire_rd = 1'b0;
      if (reset === 1'b0 && mem_req_valid === 1'b1 && mem_req_ready) begin
        log_addr.push_back(mem_req_addr);
        log_write.push_back(mem_req_write);
        log_wdata.push_back(mem_req_wdata);
        if (mem_req_write) begin
          mem_model[mem_req_addr] = mem_req_wdata;
        end else begin
          fire_rd = 1'b1;
          rd_addr = mem_req_addr;
        end
      end
      @(negedge clk);
      mem_req_ready  = ready_en;
      mem_resp_valid = fire_rd;
      mem_resp_rdata = (fire_rd && mem_model.exists(rd_addr)) ? mem_model[rd_addr] : 64'd0;
    end
  end

  // One CPU transaction; lat counts cycles from the acceptance edge to resp_valid.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [63:0] d,
                        output logic [63:0] r, output logic h, output int l);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("accept_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 64'd0;
    l = 0; r = 64'd0; h = 1'b0;
    while (l < 100) begin
      @(negedge clk);
      l++;
      if (resp_valid) begin
        r = resp_rdata;
        h = resp_hit;
        break;
      end
    end
    if (!resp_valid) check_eq("resp_timeout", 64'(resp_valid), 64'd1);
    @(negedge clk);
    check_eq("resp_one_cycle", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 64'd0;
    ready_en = 1'b1;
    mem_model[32'h40] = 64'hDEAD;
    mem_model[32'hC0] = 64'h77;
    for (int t = 0; t < 5; t++) mem_model[set2_addr(t)] = 64'hA000 + 64'(t);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_hit", 64'(resp_hit), 64'd0);
    check_eq("rst_resp_rdata", resp_rdata, 64'd0);
    check_eq("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_req_addr), 64'd0);

    // Cold read miss then hit
    do_req(1'b0, 32'h40, 64'd0, rd, hit, lat);
    check_eq("miss_data", rd, 64'hDEAD);
    check_eq("miss_hit", 64'(hit), 64'd0);
    check_eq("miss_lat", 64'(lat), 64'd4);
    check_eq("miss_memcnt", 64'(log_addr.size()), 64'd1);
    check_eq("miss_memaddr", 64'(log_addr[0]), 64'h40);
    check_eq("miss_memwr", 64'(log_write[0]), 64'd0);
    do_req(1'b0, 32'h40, 64'd0, rd, hit, lat);
    check_eq("rehit_data", rd, 64'hDEAD);
    check_eq("rehit_hit", 64'(hit), 64'd1);
    check_eq("rehit_lat", 64'(lat), 64'd2);
    check_eq("rehit_memcnt", 64'(log_addr.size()), 64'd1);

    // Write hit then read back
    do_req(1'b1, 32'h40, 64'hBEEF, rd, hit, lat);
    check_eq("wrhit_hit", 64'(hit), 64'd1);
    check_eq("wrhit_rdata", rd, 64'd0);
    check_eq("wrhit_lat", 64'(lat), 64'd2);
    do_req(1'b0, 32'h40, 64'd0, rd, hit, lat);
    check_eq("wrhit_read", rd, 64'hBEEF);

    base = log_addr.size();
`ifdef CACHE_WRITE_ALLOCATE_EN
    do_req(1'b1, 32'h2040, 64'h1111, rd, hit, lat);
    check_eq("alloc_hit", 64'(hit), 64'd0);
    check_eq("alloc_lat", 64'(lat), 64'd2);
    check_eq("alloc_nomem", 64'(log_addr.size()), 64'(base));
    do_req(1'b0, 32'h2040, 64'd0, rd, hit, lat);
    check_eq("alloc_rd_hit", 64'(hit), 64'd1);
    check_eq("alloc_rd_data", rd, 64'h1111);
`else
    do_req(1'b1, 32'h8000, 64'h5555, rd, hit, lat);
    check_eq("noalloc_hit", 64'(hit), 64'd0);
    check_eq("noalloc_lat", 64'(lat), 64'd3);
    check_eq("noalloc_memcnt", 64'(log_addr.size()), 64'(base + 1));
    check_eq("noalloc_memwr", 64'(log_write[base]), 64'd1);
    check_eq("noalloc_memaddr", 64'(log_addr[base]), 64'h8000);
    check_eq("noalloc_memdata", log_wdata[base], 64'h5555);
    do_req(1'b0, 32'h8000, 64'd0, rd, hit, lat);
    check_eq("noalloc_rd_hit", 64'(hit), 64'd0);
    check_eq("noalloc_rd_data", rd, 64'h5555);
`endif

    // Fill set 2, touch ways 0,1(write),2,3,0; the next miss evicts dirty way 1
    for (int t = 0; t < 4; t++) begin
      do_req(1'b0, set2_addr(t), 64'd0, rd, hit, lat);
      check_eq("fill_data", rd, 64'hA000 + 64'(t));
      check_eq("fill_hit", 64'(hit), 64'd0);
    end
    do_req(1'b0, set2_addr(0), 64'd0, rd, hit, lat);
    check_eq("seq_hit0", 64'(hit), 64'd1);
    do_req(1'b1, set2_addr(1), 64'hB1B1, rd, hit, lat);
    check_eq("seq_hit1", 64'(hit), 64'd1);
    do_req(1'b0, set2_addr(2), 64'd0, rd, hit, lat);
    check_eq("seq_hit2", 64'(hit), 64'd1);
    do_req(1'b0, set2_addr(3), 64'd0, rd, hit, lat);
    check_eq("seq_hit3", 64'(hit), 64'd1);
    do_req(1'b0, set2_addr(0), 64'd0, rd, hit, lat);
    check_eq("seq_hit0b", 64'(hit), 64'd1);
    base = log_addr.size();
    do_req(1'b0, set2_addr(4), 64'd0, rd, hit, lat);
    check_eq("evict_data", rd, 64'hA004);
    check_eq("evict_hit", 64'(hit), 64'd0);
    check_eq("evict_lat", 64'(lat), 64'd5);
    check_eq("evict_memcnt", 64'(log_addr.size()), 64'(base + 2));
    check_eq("wb_write", 64'(log_write[base]), 64'd1);
    check_eq("wb_addr", 64'(log_addr[base]), 64'(set2_addr(1)));
    check_eq("wb_data", log_wdata[base], 64'hB1B1);
    check_eq("refill_write", 64'(log_write[base + 1]), 64'd0);
    check_eq("refill_addr", 64'(log_addr[base + 1]), 64'(set2_addr(4)));
    do_req(1'b0, set2_addr(1), 64'd0, rd, hit, lat);
    check_eq("victim1_gone", 64'(hit), 64'd0);
    check_eq("victim1_data", rd, 64'hB1B1);
    do_req(1'b0, set2_addr(0), 64'd0, rd, hit, lat);
    check_eq("way0_kept", 64'(hit), 64'd1);
    do_req(1'b0, set2_addr(2), 64'd0, rd, hit, lat);
    check_eq("victim2_gone", 64'(hit), 64'd0);

    // Stalled refill request, then reset in the third stall cycle
    ready_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hC0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'd0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("stall_valid", 64'(mem_req_valid), 64'd1);
      check_eq("stall_addr", 64'(mem_req_addr), 64'hC0);
      check_eq("stall_write", 64'(mem_req_write), 64'd0);
      check_eq("stall_req_ready", 64'(req_ready), 64'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_req_ready", 64'(req_ready), 64'd1);
    check_eq("midrst_mem_valid", 64'(mem_req_valid), 64'd0);
    check_eq("midrst_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    ready_en = 1'b1;
    do_req(1'b0, 32'hC0, 64'd0, rd, hit, lat);
    check_eq("postrst_c0_hit", 64'(hit), 64'd0);
    check_eq("postrst_c0_data", rd, 64'h77);
    check_eq("postrst_c0_lat", 64'(lat), 64'd4);
    do_req(1'b0, 32'h40, 64'd0, rd, hit, lat);
    check_eq("postrst_40_hit", 64'(hit), 64'd0);
    check_eq("postrst_40_data", rd, 64'hDEAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/assoc_cache_ctrl.md
# assoc_cache_ctrl

- Parametrised N-way set-associative write-back cache controller with true-LRU replacement and a valid/ready memory-side port.
- Successor to the fixed 4-way/128-set controller:
  - geometry is set by parameters;
  - dirty victims are written back to memory;
  - read misses refill from memory;
  - the CPU side uses a request/response handshake.
- Sits between the CPU load/store unit and the memory interface.
- Each line holds one `DATA_W` word.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 64, line/word width.
- `WAYS`, 4, associativity; power of two, ≥2.
- `SETS`, 128, sets; power of two.
- `OFFSET_W`, 6, low address bits ignored.
- Derived widths: `IDX_W = log2(SETS)`, `TAG_W = ADDR_W - IDX_W - OFFSET_W`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1, `req_ready` out 1, `req_write` in 1, `req_addr` in `ADDR_W`, `req_wdata` in `DATA_W`: CPU request.
- `resp_valid` out 1, `resp_rdata` out `DATA_W`, `resp_hit` out 1: CPU response; always accepted.
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_write` out 1, `mem_req_addr` out `ADDR_W`, `mem_req_wdata` out `DATA_W`: memory request.
- `mem_resp_valid` in 1, `mem_resp_rdata` in `DATA_W`: refill data.

## Operation
- FSM states: `IDLE`, `LOOKUP`, `WRITEBACK`, `REFILL_REQ`, `REFILL_WAIT`, `MEM_WRITE`, `RESPOND`.
- `IDLE`:
  - `req_ready`=1; all other states drive it 0.
  - On `req_valid & req_ready`, latch write flag, address and wdata, then go to `LOOKUP`.
- `LOOKUP`: compare the latched tag against all valid ways of the indexed set.
  - Hit, read: capture line data.
  - Hit, write: store wdata and set dirty.
  - On any hit: update LRU, then go to `RESPOND` with `resp_hit`=1.
  - Miss: select the victim:
    - lowest-index invalid way, else
    - the way with the maximum LRU age.
  - Miss with victim valid & dirty: go to `WRITEBACK`.
  - Miss otherwise:
    - write miss goes to allocate (see Configuration);
    - read miss goes to `REFILL_REQ`.
- `WRITEBACK`:
  - Drive `mem_req_valid`=1, `write`=1, `addr={victim_tag, index, OFFSET_W'0}`, `wdata`=victim data.
  - Hold until `mem_req_ready`.
  - Then clear victim dirty and continue the miss path.
- `REFILL_REQ`:
  - Drive `mem_req_valid`=1, `write`=0, `addr={tag, index, 0}`.
  - On `mem_req_ready` go to `REFILL_WAIT`.
- `REFILL_WAIT`: on `mem_resp_valid`:
  - install the line (valid=1, dirty=0, tag, data);
  - update LRU;
  - go to `RESPOND` with `resp_hit`=0.
  - `mem_resp_valid` in any other state is ignored.
- Write-allocate miss:
  - Install wdata directly with no refill, since it is a full-word write.
  - Set valid=1, dirty=1; update LRU.
  - Go to `RESPOND`.
- `RESPOND`:
  - `resp_valid`=1 for exactly one cycle.
  - `resp_rdata` is valid on reads; it is 0 on writes.
  - Then return to `IDLE`.
- LRU: per-set `log2(WAYS)`-bit age per way.
  - The accessed way's age goes to 0.
  - Ways with age < its old age increment by 1.
  - Ages stay a permutation of `0..WAYS-1`.
- Reset:
  - clears all valid and dirty bits;
  - sets ages to the way index;
  - sets state to `IDLE`.
- Reset mid-transaction: the transaction is abandoned and no partial install is made.

## Timing
- Reset values: `req_ready`=1 in the cycle after reset; all other outputs 0.
- Hit latency: acceptance edge, then `LOOKUP` cycle, then `resp_valid` in the next cycle (2 cycles after acceptance).
- Miss latency:
  - 2 cycles, plus `WRITEBACK` handshake cycles (if dirty), plus `REFILL_REQ` handshake cycles, plus wait until `mem_resp_valid`;
  - `resp_valid` comes the cycle after `mem_resp_valid`.
- `mem_req_*` signals are stable while `mem_req_valid=1 & !mem_req_ready`.
- Only one outstanding transaction; back-to-back requests are accepted no faster than every 3 cycles.

## Configuration
- `CACHE_WRITE_ALLOCATE_EN` defined: write miss evicts (with writeback if dirty) and installs the line dirty.
- Undefined (write-no-allocate):
  - write miss goes to `MEM_WRITE`, which drives a memory write of `req_wdata` to the latched address until `mem_req_ready`;
  - then `RESPOND` with `resp_hit`=0;
  - no install and no LRU change.

## Structure
- Package `cache_pkg`:
  - FSM state enum;
  - `clog2`-based width localparams;
  - the address split helper (tag/index extraction).
- Sub-module `cache_lru`:
  - per-set age storage;
  - update on access;
  - combinational victim select (invalid-first, else max age);
  - parametrised by `WAYS`/`SETS`.

## Test plan
- After reset, read 0x0000_0040 → miss.
  - `mem_req` read at 0x40.
  - Return 0xDEAD; `resp_rdata`=0xDEAD, `resp_hit`=0.
  - Re-read → `resp_hit`=1 at 2 cycles, data 0xDEAD.
- Write 0x1111 to 0x2040 (allocate build) → no memory traffic, `resp_hit`=0.
  - Read 0x2040 → hit, 0x1111.
- Fill set 1 with `WAYS`+1 distinct tags (write-allocate build).
  - Expect a writeback of the first-written way's data to its address before the fifth install.
- Access ways in order 0, 1, 2, 3, 0, then miss.
  - Victim is way 1 (max age).
- Hold `mem_req_ready`=0 for 5 cycles during refill.
  - `mem_req_*` stay stable and `req_ready` stays 0.
  - Assert reset in cycle 3 → `IDLE`, line not valid, `mem_req_valid`=0.
- No-allocate build: write miss to 0x8000 → `mem_req` write of wdata, `resp_hit`=0.
  - Subsequent read to 0x8000 misses.
